if_fetch_unit: RTL

// - Instruction-fetch front end for the pipelined core; consumes the redirect target

---
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end of the pipelined core. Owns the PC, issues
// requests to instruction memory over a req/ready handshake and loads the
// IF/ID pipeline register. A one-entry skid buffer absorbs an instruction
// that returns while ID is stalled. Redirects from EX flush IF/ID and steer
// the PC, waiting out any in-flight request first (DISCARD).
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   redirect_valid : EX resolved a taken branch/jump this cycle
//   redirect_pc    : redirect target (low two bits forced to 00)
//   stall          : ID cannot accept; IF/ID must hold
//   imem_req       : registered fetch request
//   imem_addr      : registered fetch address
//   imem_ready     : memory returns imem_rdata this cycle
//   imem_rdata     : fetched instruction
//   ifid_valid     : IF/ID holds a live instruction
//   ifid_pc        : PC of the instruction in IF/ID
//   ifid_pc4       : ifid_pc + 4 (wraps modulo 2^32)
//   ifid_instr     : instruction in IF/ID
//   misalign_err   : sticky flag, a misaligned redirect target was seen
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic [31:0] skid_pc_plus4;

    // Targets are word aligned; misaligned bits are dropped and flagged.
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign pc_plus4        = pc + 32'd4;
    assign skid_pc_plus4   = skid_pc + 32'd4;

    // Single state machine owning the PC, the request outputs, the skid
    // entry and the IF/ID register. In FETCH, imem_addr always equals pc.
    // The skid entry needs no valid bit: it is only consulted in HOLD, and
    // HOLD is only entered by filling it; a redirect leaves HOLD, which is
    // what invalidates it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            pending_pc   <= RESET_PC;
            skid_pc      <= 32'h0000_0000;
            skid_instr   <= NOP_INSTR;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            ifid_valid   <= 1'b0;
            ifid_pc      <= 32'h0000_0000;
            ifid_pc4     <= 32'h0000_0000;
            ifid_instr   <= NOP_INSTR;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
            // An unanswered request must be drained before the new target
            // can be issued, since req/addr may not change until ready.
            if ((state == FETCH || state == DISCARD) && !imem_ready) begin
                pending_pc <= redirect_target;
                state      <= DISCARD;
            end else begin
                pc        <= redirect_target;
                imem_req  <= 1'b1;
                imem_addr <= redirect_target;
                state     <= FETCH;
            end
        end else begin
            case (state)
                BOOT: begin
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (imem_ready && !stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= pc;
                        ifid_pc4   <= pc_plus4;
                        ifid_instr <= imem_rdata;
                        pc         <= pc_plus4;
                        imem_addr  <= pc_plus4;
                    end else if (imem_ready && stall) begin
                        skid_pc    <= pc;
                        skid_instr <= imem_rdata;
                        pc         <= pc_plus4;
                        imem_req   <= 1'b0;
                        state      <= HOLD;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= skid_pc;
                        ifid_pc4   <= skid_pc_plus4;
                        ifid_instr <= skid_instr;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        state      <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        pc        <= pending_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= pending_pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
